// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: shared TLP type codes, completion status codes and completer FSM states.
// No ports. Imported by the completer top and the testbench.
package pcie_tlp_pkg;
    localparam logic [2:0] TLP_MEMRD = 3'd0;
    localparam logic [2:0] TLP_MEMWR = 3'd1;
    localparam logic [2:0] TLP_CPL   = 3'd2;
    localparam logic [2:0] TLP_CPLD  = 3'd3;
    localparam logic [1:0] CPL_SC    = 2'd0;
    localparam logic [1:0] CPL_UR    = 2'd1;
    localparam logic [1:0] CPL_CA    = 2'd2;
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_DROP, ST_RD, ST_UR} state_t;
endpackage

// File: rtl/pcie_tlp_completer_if.sv
// pcie_tlp_if: request and completion channels of the simplified TLP valid/ready link.
// Request channel:    req_valid/req_ready, req_type, req_addr, req_len_dw, req_tag, req_data, req_last.
// Completion channel: cpl_valid/cpl_ready, cpl_type, cpl_len_dw, cpl_tag, cpl_status, cpl_data, cpl_last.
// Modports: master = initiator (drives requests, sinks completions); slave = completer.
interface pcie_tlp_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10,
    parameter int TAG_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len_dw;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       req_data;
    logic              req_last;
    logic              cpl_valid;
    logic              cpl_ready;
    logic [2:0]        cpl_type;
    logic [LEN_W-1:0]  cpl_len_dw;
    logic [TAG_W-1:0]  cpl_tag;
    logic [1:0]        cpl_status;
    logic [31:0]       cpl_data;
    logic              cpl_last;

    modport master (
        output req_valid, req_type, req_addr, req_len_dw, req_tag, req_data, req_last, cpl_ready,
        input  req_ready, cpl_valid, cpl_type, cpl_len_dw, cpl_tag, cpl_status, cpl_data, cpl_last
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_len_dw, req_tag, req_data, req_last, cpl_ready,
        output req_ready, cpl_valid, cpl_type, cpl_len_dw, cpl_tag, cpl_status, cpl_data, cpl_last
    );
endinterface

// File: rtl/pcie_cpl_mem.sv
// pcie_cpl_mem: MEM_DEPTH x 32 register array, one write port, one combinational read port.
// Ports: clk, rst_n (async clear of every entry), i_we/i_waddr/i_wdata write port,
//        i_raddr -> o_rdata combinational read port.
module pcie_cpl_mem #(
    parameter int MEM_DEPTH = 64,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);
    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pcie_tlp_completer.sv
// pcie_tlp_completer: TLP responder servicing MemRd/MemWr against local DW memory.
// Ports: clk, rst_n (async active-low), bus (pcie_tlp_if.slave: request in, completion out).
// Optional build macro PCIE_CPL_ERR_CNT_EN adds saturating outputs ur_cnt[15:0] (UR completions
// accepted) and drop_cnt[15:0] (discarded TLPs: illegal MemWr, inbound Cpl/CplD, MemWr overrun).
module pcie_tlp_completer
    import pcie_tlp_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 10,
    parameter int TAG_W      = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int MAX_LEN_DW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pcie_tlp_if.slave   bus
`ifdef PCIE_CPL_ERR_CNT_EN
    ,
    output logic [15:0] ur_cnt,
    output logic [15:0] drop_cnt
`endif
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int AW1   = ADDR_W + 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_act;
    logic [IDX_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic             w_rdy;
    logic             w_cpl_vld;
    logic             w_req_acc;
    logic             w_cpl_acc;
    logic             w_cpl_last;
    logic             w_legal;
    logic [AW1-1:0]   w_end;
    logic [IDX_W-1:0] w_sidx;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [IDX_W-1:0] w_raddr;
    logic [31:0]      w_rdata;

    // End index is formed one bit wider than the address so it cannot wrap.
    assign w_end   = {1'b0, bus.req_addr >> 2} + AW1'(bus.req_len_dw);
    assign w_legal = bus.req_addr[1:0] == 2'b00 && bus.req_len_dw != '0 &&
                     bus.req_len_dw <= LEN_W'(MAX_LEN_DW) && w_end <= AW1'(MEM_DEPTH);
    assign w_sidx  = bus.req_addr[IDX_W+1:2];

    // r_act keeps req_ready low while in reset even though the FSM rests in IDLE.
    assign w_rdy      = r_act && (r_state == ST_IDLE || r_state == ST_WR || r_state == ST_DROP);
    assign w_cpl_vld  = r_state == ST_RD || r_state == ST_UR;
    assign w_req_acc  = bus.req_valid && w_rdy;
    assign w_cpl_acc  = w_cpl_vld && bus.cpl_ready;
    assign w_cpl_last = r_cnt == r_len - 1'b1;

    assign w_we    = w_req_acc && (r_state == ST_IDLE ? bus.req_type == TLP_MEMWR && w_legal
                                                      : r_state == ST_WR && r_cnt < r_len);
    assign w_waddr = r_state == ST_IDLE ? w_sidx : r_idx + IDX_W'(r_cnt);
    assign w_raddr = r_idx + IDX_W'(r_cnt);

    assign bus.req_ready  = w_rdy;
    assign bus.cpl_valid  = w_cpl_vld;
    assign bus.cpl_type   = r_state == ST_RD ? TLP_CPLD : r_state == ST_UR ? TLP_CPL : 3'd0;
    assign bus.cpl_len_dw = r_state == ST_RD ? r_len : '0;
    assign bus.cpl_tag    = w_cpl_vld ? r_tag : '0;
    assign bus.cpl_status = r_state == ST_UR ? CPL_UR : CPL_SC;
    assign bus.cpl_data   = r_state == ST_RD ? w_rdata : '0;
    assign bus.cpl_last   = r_state == ST_UR || (r_state == ST_RD && w_cpl_last);

    pcie_cpl_mem #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.req_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // A MemRd is single-beat, so its req_last is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_acc && bus.req_type == TLP_MEMRD)
                    w_next = w_legal ? ST_RD : ST_UR;
                else if (w_req_acc && !bus.req_last)
                    w_next = bus.req_type == TLP_MEMWR && w_legal ? ST_WR : ST_DROP;
            end
            ST_WR, ST_DROP: w_next = w_req_acc && bus.req_last ? ST_IDLE : r_state;
            ST_RD:          w_next = w_cpl_acc && w_cpl_last ? ST_IDLE : ST_RD;
            ST_UR:          w_next = w_cpl_acc ? ST_IDLE : ST_UR;
            default:        w_next = ST_IDLE;
        endcase
    end

    // r_cnt is the write beat count in WR and the read beat index in RD; it saturates at len
    // during a write so overrun beats never touch memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= 1'b0;
            r_idx <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_tag <= '0;
        end else begin
            r_act <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_req_acc) begin
                    r_idx <= w_sidx;
                    r_len <= bus.req_len_dw;
                    r_tag <= bus.req_tag;
                    r_cnt <= bus.req_type == TLP_MEMWR && !bus.req_last ? LEN_W'(1) : '0;
                end
                ST_WR: if (w_req_acc)
                    r_cnt <= bus.req_last ? '0 : r_cnt < r_len ? r_cnt + 1'b1 : r_cnt;
                ST_RD: if (w_cpl_acc)
                    r_cnt <= w_cpl_last ? '0 : r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PCIE_CPL_ERR_CNT_EN
    logic r_ovr;
    logic w_drop;
    logic w_ur;

    // An overrunning MemWr is counted once, on its first surplus beat.
    assign w_drop = w_req_acc && (r_state == ST_IDLE
        ? (bus.req_type == TLP_MEMWR && !w_legal) || bus.req_type == TLP_CPL || bus.req_type == TLP_CPLD
        : r_state == ST_WR && r_cnt >= r_len && !r_ovr);
    assign w_ur = w_cpl_acc && r_state == ST_UR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr    <= 1'b0;
            ur_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (w_req_acc)
                r_ovr <= r_state == ST_WR && (r_ovr || r_cnt >= r_len);
            if (w_ur && ur_cnt != 16'hFFFF)
                ur_cnt <= ur_cnt + 16'd1;
            if (w_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/pcie_tlp_completer.md
Name: pcie_tlp_completer

Overview:
Responder end of the team's simplified TLP valid/ready interface. Accepts MemRd, MemWr, Cpl and CplD request TLPs and services them against a local DW-addressed register memory. MemWr is posted and generates no completion; MemRd returns CplD data or a UR Cpl. Sits opposite the initiator/BFM. The same valid/ready rules apply on both its input and output ports.

Parameters:
ADDR_W, 32, request address width (byte address)
LEN_W, 10, length field width in DW
TAG_W, 8, tag width
MEM_DEPTH, 64, number of 32-bit DW entries in local memory
MAX_LEN_DW, 16, largest legal request length in DW

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  request beat valid
req_ready  out  1  request beat accepted when high with req_valid
req_type  in  3  0 MemRd, 1 MemWr, 2 Cpl, 3 CplD
req_addr  in  ADDR_W  byte address; held stable across the beats of one TLP
req_len_dw  in  LEN_W  length in DW; held stable across the beats of one TLP
req_tag  in  TAG_W  requester tag
req_data  in  32  write data DW; one DW per beat
req_last  in  1  final beat of the TLP
cpl_valid  out  1  completion beat valid
cpl_ready  in  1  completion sink ready
cpl_type  out  3  2 Cpl or 3 CplD
cpl_len_dw  out  LEN_W  completion length (0 for Cpl)
cpl_tag  out  TAG_W  echoed req_tag
cpl_status  out  2  0 SC, 1 UR
cpl_data  out  32  read data DW
cpl_last  out  1  final completion beat

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. While rst_n is low:
  - every output, including req_ready, is 0;
  - the FSM is in IDLE;
  - the beat counter and read index are 0;
  - all memory entries are 0.
  - A reset mid-TLP abandons that TLP. No partial completion is emitted after reset is released.
- Handshake: a beat transfers when valid && ready on the same posedge.
  - Once cpl_valid is asserted, it stays high and every cpl_* field stays stable until cpl_ready is sampled high.
  - cpl_valid never drops before the beat is accepted.
- Range check for a request: legal iff all of the following hold:
  - req_addr[1:0] == 0;
  - 1 <= len <= MAX_LEN_DW;
  - (req_addr >> 2) + len <= MEM_DEPTH.
  - The sum is computed at ADDR_W+1 bits, so it cannot wrap.
- FSM states: IDLE, WR, DROP, RD, UR.
- IDLE: req_ready=1. Action depends on the first beat accepted:
  - MemWr, legal: write mem[idx]=req_data, beat count=1. If req_last, stay in IDLE; otherwise go to WR.
  - MemWr, illegal: discard the beat. If not req_last, go to DROP. No completion (posted).
  - MemRd, legal: latch tag, length and start index; go to RD.
  - MemRd, illegal: latch tag; go to UR.
  - Cpl/CplD: discard the beat. If not req_last, go to DROP.
  - MemRd is single-beat. A MemRd beat with req_last=0 is still treated as complete.
- WR: req_ready=1. Each accepted beat writes mem[idx+count] while count < len, then increments count.
  - Beats beyond len are discarded.
  - The accepted beat with req_last returns the FSM to IDLE.
  - If req_last comes before len beats, the remaining words are left unwritten.
- DROP: req_ready=1. Beats are consumed until req_last, then the FSM returns to IDLE.
- RD: req_ready=0.
  - Emits len beats with cpl_type=CplD, cpl_status=SC, cpl_len_dw=len, cpl_tag=tag, cpl_data=mem[idx+i].
  - cpl_last=1 on beat len-1.
  - The first beat is valid on the cycle after the MemRd is accepted (latency 1). Subsequent beats follow back-to-back while cpl_ready=1.
  - After the last beat is accepted, the next state is IDLE and cpl_valid deasserts.
- UR: req_ready=0. Emits one beat: Cpl, status UR, len 0, data 0, cpl_last=1, same latency of 1. Returns to IDLE on acceptance.
- Only one read is outstanding at a time. Requests are stalled (req_ready=0) during RD and UR.
- The next request can be accepted on the cycle after the last completion beat is accepted. There is no same-cycle turnaround.

Optional Feature:
PCIE_CPL_ERR_CNT_EN
- Defined: adds outputs ur_cnt[15:0] and drop_cnt[15:0], both reset to 0.
  - ur_cnt increments once per UR completion accepted.
  - drop_cnt increments once per discarded TLP: an illegal MemWr, an inbound Cpl/CplD, or a MemWr overrun.
  - Both counters saturate at 16'hFFFF.
- Undefined: the counters and their ports do not exist. Datapath behaviour is otherwise identical.

Decomposition:
- Shared package pcie_tlp_pkg holds:
  - TLP type localparams TLP_MEMRD, TLP_MEMWR, TLP_CPL, TLP_CPLD;
  - completion status constants CPL_SC, CPL_UR, CPL_CA;
  - the FSM state enum.
- The FSM/decoder stays in the top module.
- One natural sub-module, pcie_cpl_mem: MEM_DEPTH x 32 register array with one write port, one combinational read port and asynchronous clear.

Test Plan:
- MemWr addr 0x10, len 2, data 0xA5A5_0001/0xA5A5_0002, then MemRd 0x10 len 2 tag 0x3C:
  - expect CplD beats with data 0xA5A5_0001 then 0xA5A5_0002, tag 0x3C, SC, cpl_last on beat 2;
  - first beat valid 1 cycle after acceptance.
- MemRd addr 0x102 (misaligned), tag 7 -> one Cpl, status UR, len 0, cpl_last=1, no data beats.
- MemRd addr (MEM_DEPTH-1)*4, len 2 -> UR. The same address with len 1 -> SC with the stored data.
- Hold cpl_ready=0 for 5 cycles during a len-4 read:
  - cpl_valid and all fields stay stable;
  - req_ready stays 0;
  - all 4 beats are delivered in order after release.
- Inbound CplD of 3 beats -> all consumed with req_ready=1, no completion, memory unchanged. drop_cnt=1 if the feature is enabled.
- Assert rst_n low during beat 2 of a len-4 read, then release:
  - outputs are 0;
  - no stale beats appear;
  - a subsequent MemRd of address 0 returns 0.
